// File: rtl/dcache_pkg.sv
// dcache_pkg: fixed geometry, controller state type and address field helpers
// shared by data_cache_unit and its controller.
package dcache_pkg;
    localparam int ADDR_W     = 8;
    localparam int TAG_W      = 3;
    localparam int INDEX_W    = 3;
    localparam int OFFSET_W   = 2;
    localparam int BLOCK_W    = 32;
    localparam int LINES      = 8;
    localparam int MEM_ADDR_W = TAG_W + INDEX_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH,
        UPDATE
    } dcache_state_e;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W-1:0];
    endfunction
endpackage

// File: rtl/dcache_ctrl_fsm.sv
// dcache_ctrl_fsm: miss-handling controller for data_cache_unit. Sequences
// write-back of a dirty victim and the block fetch, with registered memory requests.
module dcache_ctrl_fsm
    import dcache_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  hit,
    input  logic                  victim_dirty,
    input  logic [TAG_W-1:0]      req_tag,
    input  logic [TAG_W-1:0]      victim_tag,
    input  logic [INDEX_W-1:0]    index,
    input  logic [BLOCK_W-1:0]    victim_data,
    input  logic [BLOCK_W-1:0]    mem_readdata,
    input  logic                  mem_busywait,
    output dcache_state_e         state,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [MEM_ADDR_W-1:0] mem_address,
    output logic [BLOCK_W-1:0]    mem_writedata,
    output logic [BLOCK_W-1:0]    fetch_block
);

    // Request outputs are loaded on entry to a state so they stay stable for its whole duration.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            fetch_block   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && !hit) begin
                        if (victim_dirty) begin
                            state         <= WRITEBACK;
                            mem_write     <= 1'b1;
                            mem_address   <= {victim_tag, index};
                            mem_writedata <= victim_data;
                        end else begin
                            state       <= FETCH;
                            mem_read    <= 1'b1;
                            mem_address <= {req_tag, index};
                        end
                    end
                end
                WRITEBACK: begin
                    if (!mem_busywait) begin
                        state         <= FETCH;
                        mem_write     <= 1'b0;
                        mem_writedata <= '0;
                        mem_read      <= 1'b1;
                        mem_address   <= {req_tag, index};
                    end
                end
                FETCH: begin
                    if (!mem_busywait) begin
                        state       <= UPDATE;
                        mem_read    <= 1'b0;
                        mem_address <= '0;
                        fetch_block <= mem_readdata;
                    end
                end
                UPDATE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/data_cache_unit.sv
// data_cache_unit: 8-line direct-mapped write-back data cache with 4-byte blocks.
// Optional hit/miss counters are enabled with the DCACHE_PERF_EN macro.
module data_cache_unit
    import dcache_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_W-1:0]     ADDRESS,
    input  logic [7:0]            WRITEDATA,
    output logic [7:0]            READDATA,
    output logic                  BUSYWAIT,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [MEM_ADDR_W-1:0] mem_address,
    output logic [BLOCK_W-1:0]    mem_writedata,
    input  logic [BLOCK_W-1:0]    mem_readdata,
    input  logic                  mem_busywait
`ifdef DCACHE_PERF_EN
    ,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
`endif
);

    logic [BLOCK_W-1:0]  data_arr [LINES];
    logic [TAG_W-1:0]    tag_arr  [LINES];
    logic [LINES-1:0]    valid_bits;
    logic [LINES-1:0]    dirty_bits;

    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
    logic [BLOCK_W-1:0]  cur_line;
    logic [BLOCK_W-1:0]  fetch_block;
    logic                req;
    logic                hit;
    dcache_state_e       state;

    assign tag      = addr_tag(ADDRESS);
    assign index    = addr_index(ADDRESS);
    assign offset   = addr_offset(ADDRESS);
    assign cur_line = data_arr[index];
    assign req      = READ | WRITE;
    assign hit      = valid_bits[index] && (tag_arr[index] == tag);

    assign READDATA = cur_line[{offset, 3'b000} +: 8];
    assign BUSYWAIT = req && !(state == IDLE && hit);

    dcache_ctrl_fsm u_ctrl (
        .clk           (CLK),
        .reset         (RESET),
        .req           (req),
        .hit           (hit),
        .victim_dirty  (valid_bits[index] && dirty_bits[index]),
        .req_tag       (tag),
        .victim_tag    (tag_arr[index]),
        .index         (index),
        .victim_data   (cur_line),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait),
        .state         (state),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .fetch_block   (fetch_block)
    );

    // A refill lands in UPDATE; a store writes only when it hits in IDLE, which
    // also covers the retried store of a write miss.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < LINES; i++) begin
                data_arr[i] <= '0;
                tag_arr[i]  <= '0;
            end
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (state == UPDATE) begin
            data_arr[index]   <= fetch_block;
            tag_arr[index]    <= tag;
            valid_bits[index] <= 1'b1;
            dirty_bits[index] <= 1'b0;
        end else if (state == IDLE && WRITE && hit) begin
            data_arr[index][{offset, 3'b000} +: 8] <= WRITEDATA;
            dirty_bits[index] <= 1'b1;
        end
    end

`ifdef DCACHE_PERF_EN
    logic retry_q;

    // retry_q marks the IDLE cycle right after a refill so the replayed hit is not counted.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            retry_q    <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            retry_q <= (state == UPDATE);
            if (state == IDLE && req) begin
                if (hit) begin
                    if (!retry_q && hit_count != 16'hFFFF) begin
                        hit_count <= hit_count + 16'd1;
                    end
                end else if (miss_count != 16'hFFFF) begin
                    miss_count <= miss_count + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_cache_unit.sv
// tb_data_cache_unit: directed vector table, a mid-refill reset sequence and
// random traffic against a flat-memory reference model of the cache.
module tb_data_cache_unit;

    localparam int MAX_STALL = 60;

    logic        clk = 1'b0;
    logic        reset;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;
`ifdef DCACHE_PERF_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    data_cache_unit dut (
        .CLK           (clk),
        .RESET         (reset),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
`ifdef DCACHE_PERF_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    function automatic logic [31:0] init_block(input int b);
        logic [31:0] blk;
        if (b == 1) return 32'hDDCCBBAA;
        for (int i = 0; i < 4; i++) blk[8*i +: 8] = 8'((b * 4 + i) * 13 + 7);
        return blk;
    endfunction

    // Block memory: busy for 'lat' cycles after a request appears, then completes.
    logic [31:0] dram [64];
    bit          dram_ready;
    int          rd_cnt;
    int          wr_cnt;
    int          lat = 2;

    assign mem_busywait = (mem_read && rd_cnt < lat) || (mem_write && wr_cnt < lat);
    assign mem_readdata = mem_read ? dram[mem_address] : 32'h0;

    always @(posedge clk) begin
        rd_cnt <= mem_read ? rd_cnt + 1 : 0;
        wr_cnt <= mem_write ? wr_cnt + 1 : 0;
        if (!dram_ready) begin
            for (int b = 0; b < 64; b++) dram[b] <= init_block(b);
            dram_ready <= 1'b1;
        end else if (mem_write && !mem_busywait) begin
            dram[mem_address] <= mem_writedata;
        end
    end

    // Reference model: a coherent byte view plus the blocks the backing memory should hold.
    logic [7:0] ref_mem  [256];
    logic [7:0] back_mem [256];
    bit         res_valid [8];
    bit         res_dirty [8];
    int         res_block [8];
    int         m_hits;
    int         m_misses;

    function automatic void model_init();
        for (int b = 0; b < 64; b++) begin
            logic [31:0] blk;
            blk = init_block(b);
            for (int i = 0; i < 4; i++) begin
                ref_mem[b*4+i]  = blk[8*i +: 8];
                back_mem[b*4+i] = blk[8*i +: 8];
            end
        end
        for (int i = 0; i < 8; i++) begin
            res_valid[i] = 0;
            res_dirty[i] = 0;
            res_block[i] = 0;
        end
        m_hits   = 0;
        m_misses = 0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            if (res_valid[i] && res_dirty[i])
                for (int k = 0; k < 4; k++) ref_mem[res_block[i]*4+k] = back_mem[res_block[i]*4+k];
            res_valid[i] = 0;
            res_dirty[i] = 0;
        end
        m_hits   = 0;
        m_misses = 0;
    endfunction

    function automatic void model_access(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                                         output int stalls, output logic [7:0] rdata,
                                         output bit wb, output logic [5:0] wb_addr,
                                         output logic [31:0] wb_data, output logic [5:0] fetch_addr);
        int blk;
        int idx;
        blk = int'(addr) / 4;
        idx = blk % 8;
        stalls = 0; wb = 0; wb_addr = '0; wb_data = '0; fetch_addr = '0;
        if (res_valid[idx] && res_block[idx] == blk) begin
            m_hits++;
        end else begin
            m_misses++;
            stalls = lat + 3;
            if (res_valid[idx] && res_dirty[idx]) begin
                wb = 1;
                wb_addr = 6'(res_block[idx]);
                for (int k = 0; k < 4; k++) begin
                    wb_data[8*k +: 8] = ref_mem[res_block[idx]*4+k];
                    back_mem[res_block[idx]*4+k] = ref_mem[res_block[idx]*4+k];
                end
                stalls += lat + 1;
            end
            fetch_addr = 6'(blk);
            res_valid[idx] = 1;
            res_dirty[idx] = 0;
            res_block[idx] = blk;
        end
        if (wr) begin
            ref_mem[addr] = wdata;
            res_dirty[idx] = 1;
        end
        rdata = ref_mem[addr];
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input bit rd, input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                                  output int stalls, output logic [7:0] rdata,
                                  output bit saw_wb, output logic [5:0] wb_addr, output logic [31:0] wb_data,
                                  output bit saw_fetch, output logic [5:0] fetch_addr,
                                  output bit bus_idle, output bit timed_out);
        READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wdata;
        stalls = 0; saw_wb = 0; wb_addr = '0; wb_data = '0; saw_fetch = 0; fetch_addr = '0;
        @(negedge clk);
        while (BUSYWAIT && stalls < MAX_STALL) begin
            stalls++;
            if (mem_write && !saw_wb) begin
                saw_wb = 1; wb_addr = mem_address; wb_data = mem_writedata;
            end
            if (mem_read && !saw_fetch) begin
                saw_fetch = 1; fetch_addr = mem_address;
            end
            @(negedge clk);
        end
        timed_out = BUSYWAIT;
        rdata     = READDATA;
        bus_idle  = !mem_read && !mem_write;
        @(posedge clk);
        #1;
        READ = 0; WRITE = 0;
    endtask

    // One request checked against the reference model.
    task automatic run_and_check(input bit rd, input bit wr, input logic [7:0] addr, input logic [7:0] wdata);
        int e_stalls, a_stalls;
        logic [7:0] e_rdata, a_rdata;
        bit e_wb, a_wb, a_fetch, idle, tmo;
        logic [5:0] e_wb_addr, a_wb_addr, e_fetch_addr, a_fetch_addr;
        logic [31:0] e_wb_data, a_wb_data;
        model_access(wr, addr, wdata, e_stalls, e_rdata, e_wb, e_wb_addr, e_wb_data, e_fetch_addr);
        apply_stimulus(rd, wr, addr, wdata, a_stalls, a_rdata, a_wb, a_wb_addr, a_wb_data,
                       a_fetch, a_fetch_addr, idle, tmo);
        check_output("busywait_timeout", 32'(tmo), 32'd0);
        check_output($sformatf("stalls@%h", addr), 32'(a_stalls), 32'(e_stalls));
        if (rd && !wr) check_output($sformatf("readdata@%h", addr), 32'(a_rdata), 32'(e_rdata));
        check_output("writeback_seen", 32'(a_wb), 32'(e_wb));
        if (e_wb) begin
            check_output("wb_address", 32'(a_wb_addr), 32'(e_wb_addr));
            check_output("wb_data", a_wb_data, e_wb_data);
        end
        if (e_stalls != 0) check_output("fetch_address", 32'(a_fetch_addr), 32'(e_fetch_addr));
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        bit          chk_rdata;
        logic [7:0]  exp_rdata;
        int          exp_stalls;
        bit          exp_wb;
        logic [5:0]  exp_wb_addr;
        logic [31:0] exp_wb_data;
        bit          exp_fetch;
        logic [5:0]  exp_fetch_addr;
    } vec_t;

    vec_t vecs [11];

    initial begin
        logic [31:0] b4, b9, b12;
        int a_stalls, d_stalls;
        logic [7:0] a_rdata, d_rdata;
        bit a_wb, a_fetch, idle, tmo, d_wb;
        logic [5:0] a_wb_addr, a_fetch_addr, d_wb_addr, d_fetch_addr;
        logic [31:0] a_wb_data, d_wb_data;
        int guard;
        int bad_blocks;

        b4  = init_block(4);
        b9  = init_block(9);
        b12 = init_block(12);
        // Directed vectors with memory latency 2: clean miss stalls 5 cycles, dirty miss 8.
        vecs[0]  = '{1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 8'hBB,     5, 1'b0, 6'h00, 32'h0,        1'b1, 6'h01};
        vecs[1]  = '{1'b1, 1'b0, 8'h06, 8'h00, 1'b1, 8'hCC,     0, 1'b0, 6'h00, 32'h0,        1'b0, 6'h00};
        vecs[2]  = '{1'b0, 1'b1, 8'h04, 8'h5A, 1'b0, 8'h00,     0, 1'b0, 6'h00, 32'h0,        1'b0, 6'h00};
        vecs[3]  = '{1'b1, 1'b0, 8'h04, 8'h00, 1'b1, 8'h5A,     0, 1'b0, 6'h00, 32'h0,        1'b0, 6'h00};
        vecs[4]  = '{1'b1, 1'b0, 8'h24, 8'h00, 1'b1, b9[7:0],   8, 1'b1, 6'h01, 32'hDDCCBB5A, 1'b1, 6'h09};
        vecs[5]  = '{1'b0, 1'b1, 8'h10, 8'h77, 1'b0, 8'h00,     5, 1'b0, 6'h00, 32'h0,        1'b1, 6'h04};
        vecs[6]  = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 8'h77,     0, 1'b0, 6'h00, 32'h0,        1'b0, 6'h00};
        vecs[7]  = '{1'b1, 1'b0, 8'h04, 8'h00, 1'b1, 8'h5A,     5, 1'b0, 6'h00, 32'h0,        1'b1, 6'h01};
        vecs[8]  = '{1'b1, 1'b1, 8'h05, 8'h99, 1'b0, 8'h00,     0, 1'b0, 6'h00, 32'h0,        1'b0, 6'h00};
        vecs[9]  = '{1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 8'h99,     0, 1'b0, 6'h00, 32'h0,        1'b0, 6'h00};
        vecs[10] = '{1'b1, 1'b0, 8'h30, 8'h00, 1'b1, b12[7:0],  8, 1'b1, 6'h04, {b4[31:8], 8'h77}, 1'b1, 6'h0C};

        model_init();
        reset = 1; READ = 0; WRITE = 0; ADDRESS = '0; WRITEDATA = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        @(negedge clk);
        check_output("reset_busywait", 32'(BUSYWAIT), 32'd0);
        check_output("reset_mem_read", 32'(mem_read), 32'd0);
        check_output("reset_mem_write", 32'(mem_write), 32'd0);
        check_output("reset_readdata", 32'(READDATA), 32'd0);
        @(posedge clk);
        #1;

        lat = 2;
        for (int v = 0; v < 11; v++) begin
            model_access(vecs[v].wr, vecs[v].addr, vecs[v].wdata, d_stalls, d_rdata, d_wb,
                         d_wb_addr, d_wb_data, d_fetch_addr);
            apply_stimulus(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata, a_stalls, a_rdata,
                           a_wb, a_wb_addr, a_wb_data, a_fetch, a_fetch_addr, idle, tmo);
            check_output($sformatf("vec%0d_timeout", v), 32'(tmo), 32'd0);
            check_output($sformatf("vec%0d_stalls", v), 32'(a_stalls), 32'(vecs[v].exp_stalls));
            if (vecs[v].chk_rdata)
                check_output($sformatf("vec%0d_readdata", v), 32'(a_rdata), 32'(vecs[v].exp_rdata));
            check_output($sformatf("vec%0d_wb_seen", v), 32'(a_wb), 32'(vecs[v].exp_wb));
            if (vecs[v].exp_wb) begin
                check_output($sformatf("vec%0d_wb_addr", v), 32'(a_wb_addr), 32'(vecs[v].exp_wb_addr));
                check_output($sformatf("vec%0d_wb_data", v), a_wb_data, vecs[v].exp_wb_data);
            end
            check_output($sformatf("vec%0d_fetch_seen", v), 32'(a_fetch), 32'(vecs[v].exp_fetch));
            if (vecs[v].exp_fetch)
                check_output($sformatf("vec%0d_fetch_addr", v), 32'(a_fetch_addr), 32'(vecs[v].exp_fetch_addr));
            check_output($sformatf("vec%0d_bus_idle", v), 32'(idle), 32'd1);
        end

        // Reset in the middle of a refill: line 1 holds a dirty block, so 0x44 writes back first.
        lat = 3;
        model_access(1'b0, 8'h44, 8'h00, d_stalls, d_rdata, d_wb, d_wb_addr, d_wb_data, d_fetch_addr);
        READ = 1; WRITE = 0; ADDRESS = 8'h44;
        guard = 0;
        @(negedge clk);
        while (!mem_read && guard < MAX_STALL) begin
            guard++;
            @(negedge clk);
        end
        check_output("reset_seq_fetch_reached", 32'(mem_read), 32'd1);
        reset = 1;
        @(negedge clk);
        check_output("midfetch_reset_mem_read", 32'(mem_read), 32'd0);
        check_output("midfetch_reset_mem_write", 32'(mem_write), 32'd0);
        check_output("midfetch_reset_readdata", 32'(READDATA), 32'd0);
        check_output("midfetch_reset_busywait", 32'(BUSYWAIT), 32'd1);
        reset = 0;
        READ = 0;
        model_reset();
        @(posedge clk);
        #1;
        run_and_check(1'b1, 1'b0, 8'h05, 8'h00);

        for (int n = 0; n < 300; n++) begin
            int op;
            lat = int'($urandom_range(0, 3));
            op  = int'($urandom_range(0, 3));
            run_and_check(op != 2, op >= 2, 8'($urandom_range(0, 127)), 8'($urandom));
        end

        bad_blocks = 0;
        for (int b = 0; b < 64; b++)
            if (dram[b] !== {back_mem[b*4+3], back_mem[b*4+2], back_mem[b*4+1], back_mem[b*4]})
                bad_blocks++;
        check_output("dram_blocks_differing", 32'(bad_blocks), 32'd0);
`ifdef DCACHE_PERF_EN
        check_output("hit_count", 32'(hit_count), 32'(m_hits));
        check_output("miss_count", 32'(miss_count), 32'(m_misses));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
